// File: rtl/para_loader_layer3_pkg.sv
// Shared constants and types for the layer 3 parameter loader.
package para_loader_layer3_pkg;

  localparam int unsigned PARA_WIDTH = 16;
  localparam int unsigned PARA_NUM   = 6;
  localparam int unsigned TYPE_W     = $clog2(PARA_NUM);

  // Parameter type indices, in stream order
  localparam int unsigned RSIGN    = 0;
  localparam int unsigned BN_A     = 1;
  localparam int unsigned BN_B     = 2;
  localparam int unsigned RP_BETA  = 3;
  localparam int unsigned RP_GAMMA = 4;
  localparam int unsigned RP_ZETA  = 5;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StDone
  } state_e;

endpackage

// File: rtl/para_loader_layer3_if.sv
// Parameter stream input and per-channel parameter arrays of the layer 3 loader.
interface para_loader_layer3_if #(
  parameter int unsigned FM_DEPTH = 128
);
  import para_loader_layer3_pkg::*;

  logic                  mode_in;
  logic                  para_e;
  logic [PARA_WIDTH-1:0] para_in;

  logic [PARA_WIDTH-1:0] rsign_para   [FM_DEPTH];
  logic [PARA_WIDTH-1:0] bn_a         [FM_DEPTH];
  logic [PARA_WIDTH-1:0] bn_b         [FM_DEPTH];
  logic [PARA_WIDTH-1:0] rprelu_beta  [FM_DEPTH];
  logic [PARA_WIDTH-1:0] rprelu_gamma [FM_DEPTH];
  logic [PARA_WIDTH-1:0] rprelu_zeta  [FM_DEPTH];
  logic                  load_done;
  logic                  load_err;

  modport master (
    output mode_in, para_e, para_in,
    input  rsign_para, bn_a, bn_b, rprelu_beta, rprelu_gamma, rprelu_zeta,
    input  load_done, load_err
  );

  modport slave (
    input  mode_in, para_e, para_in,
    output rsign_para, bn_a, bn_b, rprelu_beta, rprelu_gamma, rprelu_zeta,
    output load_done, load_err
  );

endinterface

// File: rtl/para_loader_layer3_para_addr_cnt.sv
// Channel/type write-address counter pair with wrap and last-word flag.
// The address outputs already reflect a same-cycle clear, so the word that
// arrives together with load start lands at channel 0, type 0.
module para_loader_layer3_para_addr_cnt #(
  parameter int unsigned FM_DEPTH     = 128,
  parameter int unsigned LOG2FM_DEPTH = 7,
  parameter int unsigned NUM_TYPES    = 6,
  parameter int unsigned TYPE_W       = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    inc,
  output logic [LOG2FM_DEPTH-1:0] ch_addr,
  output logic [TYPE_W-1:0]       type_addr,
  output logic                    last
);

  logic [LOG2FM_DEPTH-1:0] ch_cnt_q, ch_cnt_d;
  logic [TYPE_W-1:0]       type_cnt_q, type_cnt_d;
  logic                    ch_wrap;

  // Effective address and next counter values
  always_comb begin
    ch_addr    = clr ? '0 : ch_cnt_q;
    type_addr  = clr ? '0 : type_cnt_q;
    ch_wrap    = (ch_addr == LOG2FM_DEPTH'(FM_DEPTH - 1));
    last       = ch_wrap && (type_addr == TYPE_W'(NUM_TYPES - 1));
    ch_cnt_d   = ch_addr;
    type_cnt_d = type_addr;
    if (inc) begin
      if (ch_wrap) begin
        ch_cnt_d   = '0;
        type_cnt_d = last ? '0 : type_addr + 1'b1;
      end else begin
        ch_cnt_d = ch_addr + 1'b1;
      end
    end
  end

  // Counter state
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_cnt_q   <= '0;
      type_cnt_q <= '0;
    end else begin
      ch_cnt_q   <= ch_cnt_d;
      type_cnt_q <= type_cnt_d;
    end
  end

endmodule

// File: rtl/para_loader_layer3.sv
// Layer 3 parameter loader: scatters a serial type-major word stream into
// per-channel RSign/BN/RPReLU registers and reports load completion/abort.
module para_loader_layer3
  import para_loader_layer3_pkg::*;
#(
  parameter int unsigned FM_DEPTH     = 128,
  parameter int unsigned LOG2FM_DEPTH = 7
) (
  input logic            clk,
  input logic            rst,
  para_loader_layer3_if.slave bus
);

  logic                    mode_q;
  state_e                  state_q;
  logic                    load_done_q;
  logic                    load_err_q;
  logic                    load_start;
  logic                    accept;
  logic                    last;
  logic [LOG2FM_DEPTH-1:0] ch_addr;
  logic [TYPE_W-1:0]       type_addr;

  // Outputs are these registers directly; downstream reads them only in calculate mode
  logic [PARA_WIDTH-1:0]   para_q [PARA_NUM][FM_DEPTH];

  assign load_start = ~bus.mode_in & mode_q;
  assign accept     = bus.para_e & ~bus.mode_in & ((state_q == StLoad) | load_start);

  para_loader_layer3_para_addr_cnt #(
    .FM_DEPTH     (FM_DEPTH),
    .LOG2FM_DEPTH (LOG2FM_DEPTH),
    .NUM_TYPES    (PARA_NUM),
    .TYPE_W       (TYPE_W)
  ) u_addr_cnt (
    .clk       (clk),
    .rst       (rst),
    .clr       (load_start),
    .inc       (accept),
    .ch_addr   (ch_addr),
    .type_addr (type_addr),
    .last      (last)
  );

  // Load FSM with registered status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q      <= 1'b1;
      state_q     <= StIdle;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
    end else begin
      mode_q <= bus.mode_in;
      if (load_start) begin
        state_q     <= StLoad;
        load_done_q <= 1'b0;
        load_err_q  <= 1'b0;
      end else begin
        unique case (state_q)
          StLoad: begin
            if (bus.mode_in) begin
              // Abort: partially written registers are kept as they are
              state_q    <= StIdle;
              load_err_q <= 1'b1;
            end else if (accept && last) begin
              state_q     <= StDone;
              load_done_q <= 1'b1;
            end
          end
          StIdle, StDone: ;
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Parameter storage write decode
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int t = 0; t < PARA_NUM; t++) begin
        for (int c = 0; c < FM_DEPTH; c++) begin
          para_q[t][c] <= '0;
        end
      end
    end else if (accept) begin
      para_q[type_addr][ch_addr] <= bus.para_in;
    end
  end

  for (genvar c = 0; c < FM_DEPTH; c++) begin : g_out
    assign bus.rsign_para[c]   = para_q[RSIGN][c];
    assign bus.bn_a[c]         = para_q[BN_A][c];
    assign bus.bn_b[c]         = para_q[BN_B][c];
    assign bus.rprelu_beta[c]  = para_q[RP_BETA][c];
    assign bus.rprelu_gamma[c] = para_q[RP_GAMMA][c];
    assign bus.rprelu_zeta[c]  = para_q[RP_ZETA][c];
  end

  assign bus.load_done = load_done_q;
  assign bus.load_err  = load_err_q;

endmodule

// File: tb/tb_para_loader_layer3.sv
// Scoreboard bench for para_loader_layer3: stimulus pushes expected values,
// a negedge monitor pops and compares; a second check tracks load_done rises.
module tb_para_loader_layer3;

  localparam int SEL_DONE = 6;
  localparam int SEL_ERR  = 7;
  localparam int SEL_PEND = 8;

  typedef struct {
    string       name;
    int          sel;
    int          idx;
    logic [15:0] val;
  } chk_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  logic done_prev = 1'b0;

  chk_t exp_q[$];
  int   done_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  para_loader_layer3_if #(.FM_DEPTH(128)) bus ();

  para_loader_layer3 #(
    .FM_DEPTH     (128),
    .LOG2FM_DEPTH (7)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic logic [15:0] read_dut(input int sel, input int idx);
    case (sel)
      0:        return bus.rsign_para[idx];
      1:        return bus.bn_a[idx];
      2:        return bus.bn_b[idx];
      3:        return bus.rprelu_beta[idx];
      4:        return bus.rprelu_gamma[idx];
      5:        return bus.rprelu_zeta[idx];
      SEL_DONE: return {15'd0, bus.load_done};
      SEL_ERR:  return {15'd0, bus.load_err};
      default:  return 16'(done_q.size());
    endcase
  endfunction

  // Monitor: compare every queued expectation against the DUT at the falling edge
  always @(negedge clk) begin
    chk_t        c;
    logic [15:0] act;
    int          want;
    while (exp_q.size() > 0) begin
      c   = exp_q.pop_front();
      act = read_dut(c.sel, c.idx);
      n_checks++;
      if (act !== c.val) begin
        n_errors++;
        $display("FAIL %s: got %h, expected %h (t=%0t)", c.name, act, c.val, $time);
      end
    end
    if (bus.load_done === 1'b1 && done_prev !== 1'b1) begin
      n_checks++;
      if (done_q.size() == 0) begin
        n_errors++;
        $display("FAIL done_rise: unexpected rise at cycle %0d, expected none", cyc);
      end else begin
        want = done_q.pop_front();
        if (cyc != want) begin
          n_errors++;
          $display("FAIL done_rise: rose at cycle %0d, expected cycle %0d", cyc, want);
        end
      end
    end
    done_prev = bus.load_done;
  end

  task automatic chk(input string name, input int sel, input int idx, input logic [15:0] val);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.idx  = idx;
    c.val  = val;
    exp_q.push_back(c);
  endtask

  // Apply inputs for the next edge; checks pushed afterwards see state after this edge
  task automatic drive(input logic m, input logic e, input logic [15:0] d);
    @(posedge clk);
    #1;
    bus.mode_in = m;
    bus.para_e  = e;
    bus.para_in = d;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.mode_in = 1'b1;
    bus.para_e  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.mode_in = 1'b1;
    bus.para_e  = 1'b0;
    bus.para_in = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst_rsign0", 0, 0, 16'h0);
    chk("rst_zeta127", 5, 127, 16'h0);
    chk("rst_done", SEL_DONE, 0, 16'h0);
    chk("rst_err", SEL_ERR, 0, 16'h0);

    // Full continuous load, word k = k
    for (int k = 0; k < 768; k++) begin
      drive(1'b0, 1'b1, 16'(k));
      if (k == 767) begin
        chk("full_done_before_last", SEL_DONE, 0, 16'h0);
        done_q.push_back(cyc + 1);
      end
    end
    drive(1'b1, 1'b0, 16'h0);
    chk("full_rsign5", 0, 5, 16'd5);
    chk("full_bn_a0", 1, 0, 16'd128);
    chk("full_bn_b1", 2, 1, 16'd257);
    chk("full_beta64", 3, 64, 16'd448);
    chk("full_gamma3", 4, 3, 16'd515);
    chk("full_zeta127", 5, 127, 16'd767);
    chk("full_done", SEL_DONE, 0, 16'h1);
    chk("full_err", SEL_ERR, 0, 16'h0);

    // Calculate-mode noise must not disturb anything
    for (int i = 0; i < 100; i++) drive(1'b1, 1'b1, 16'($urandom));
    drive(1'b1, 1'b0, 16'h0);
    chk("calc_rsign5", 0, 5, 16'd5);
    chk("calc_bn_a0", 1, 0, 16'd128);
    chk("calc_beta64", 3, 64, 16'd448);
    chk("calc_zeta127", 5, 127, 16'd767);
    chk("calc_done", SEL_DONE, 0, 16'h1);
    chk("calc_err", SEL_ERR, 0, 16'h0);

    // Gapped stream with junk data on the idle cycles, word k = 0x8000|k
    for (int k = 0; k < 768; k++) begin
      drive(1'b0, 1'b1, 16'h8000 | 16'(k));
      if (k == 767) begin
        chk("gap_done_before_last", SEL_DONE, 0, 16'h0);
        done_q.push_back(cyc + 1);
      end
      drive(1'b0, 1'b0, 16'($urandom));
    end
    drive(1'b1, 1'b0, 16'h0);
    chk("gap_rsign5", 0, 5, 16'h8005);
    chk("gap_bn_a0", 1, 0, 16'h8080);
    chk("gap_zeta127", 5, 127, 16'h82FF);
    chk("gap_done", SEL_DONE, 0, 16'h1);
    chk("gap_err", SEL_ERR, 0, 16'h0);

    // 800 words: the 32 beyond a full set are ignored
    for (int k = 0; k < 800; k++) begin
      drive(1'b0, 1'b1, 16'(k));
      if (k == 767) begin
        chk("extra_done_before_last", SEL_DONE, 0, 16'h0);
        done_q.push_back(cyc + 1);
      end
    end
    drive(1'b1, 1'b0, 16'h0);
    chk("extra_rsign0", 0, 0, 16'd0);
    chk("extra_rsign31", 0, 31, 16'd31);
    chk("extra_zeta127", 5, 127, 16'd767);
    chk("extra_done", SEL_DONE, 0, 16'h1);
    chk("extra_err", SEL_ERR, 0, 16'h0);

    // Reset while word 400 is on the bus
    for (int k = 0; k < 400; k++) drive(1'b0, 1'b1, 16'h3000 | 16'(k));
    drive(1'b0, 1'b1, 16'h3000 | 16'd400);
    chk("pre_rst_bn_b0", 2, 0, 16'h3100);
    chk("pre_rst_beta15", 3, 15, 16'h318F);
    rst = 1'b1;
    drive(1'b1, 1'b0, 16'h0);
    rst = 1'b0;
    for (int t = 0; t < 6; t++) begin
      for (int c = 0; c < 128; c++) chk($sformatf("midrst_t%0d_c%0d", t, c), t, c, 16'h0);
    end
    chk("midrst_done", SEL_DONE, 0, 16'h0);
    chk("midrst_err", SEL_ERR, 0, 16'h0);

    // Full load after the mid-load reset
    for (int k = 0; k < 768; k++) begin
      drive(1'b0, 1'b1, 16'h5000 | 16'(k));
      if (k == 767) done_q.push_back(cyc + 1);
    end
    drive(1'b1, 1'b0, 16'h0);
    chk("reload_rsign5", 0, 5, 16'h5005);
    chk("reload_bn_a0", 1, 0, 16'h5080);
    chk("reload_zeta127", 5, 127, 16'h52FF);
    chk("reload_done", SEL_DONE, 0, 16'h1);
    chk("reload_err", SEL_ERR, 0, 16'h0);

    // Abort after 300 words: word 299 is bn_b[43], bn_b[44] never written
    do_reset();
    for (int k = 0; k < 300; k++) drive(1'b0, 1'b1, 16'(k));
    drive(1'b1, 1'b1, 16'hFFFF);
    drive(1'b1, 1'b0, 16'h0);
    chk("abort_err", SEL_ERR, 0, 16'h1);
    chk("abort_done", SEL_DONE, 0, 16'h0);
    chk("abort_bn_b43", 2, 43, 16'd299);
    chk("abort_bn_b44", 2, 44, 16'h0);
    chk("abort_bn_a127", 1, 127, 16'd255);
    chk("abort_beta0", 3, 0, 16'h0);
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b1, 16'hEEEE);
    chk("idle_bn_b44", 2, 44, 16'h0);
    chk("idle_err", SEL_ERR, 0, 16'h1);

    // New load start clears load_err
    drive(1'b0, 1'b0, 16'h0);
    drive(1'b0, 1'b0, 16'h0);
    chk("restart_err", SEL_ERR, 0, 16'h0);

    // One-cycle mode glitch aborts; following low cycle restarts at word 0
    for (int k = 0; k < 10; k++) drive(1'b0, 1'b1, 16'h7000 | 16'(k));
    drive(1'b1, 1'b1, 16'hFFFF);
    drive(1'b0, 1'b1, 16'h7100);
    chk("glitch_err", SEL_ERR, 0, 16'h1);
    drive(1'b0, 1'b1, 16'h7101);
    chk("glitch_restart_err", SEL_ERR, 0, 16'h0);
    for (int k = 2; k < 5; k++) drive(1'b0, 1'b1, 16'h7100 | 16'(k));
    drive(1'b1, 1'b0, 16'h0);
    chk("glitch_rsign0", 0, 0, 16'h7100);
    chk("glitch_rsign4", 0, 4, 16'h7104);
    chk("glitch_rsign5", 0, 5, 16'h7005);
    chk("glitch_rsign9", 0, 9, 16'h7009);
    chk("glitch_rsign10", 0, 10, 16'd10);
    chk("glitch_done", SEL_DONE, 0, 16'h0);
    chk("glitch_err_pre", SEL_ERR, 0, 16'h0);
    drive(1'b1, 1'b0, 16'h0);
    chk("glitch_final_err", SEL_ERR, 0, 16'h1);

    // All expected load_done rises must have been seen
    drive(1'b1, 1'b0, 16'h0);
    chk("done_rises_pending", SEL_PEND, 0, 16'h0);
    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
